// File: rtl/fp_mul_arb_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_arb_pkg
// Shared definitions for the FP8 multiplier arbiter and other FP8 blocks.
//   state_t   : arbiter FSM states (IDLE, WAIT, RESP)
//   MAX_REQ   : largest supported requester count
//   FP8_*     : field positions of the 1|3|4 sign/exponent/mantissa format
// -----------------------------------------------------------------------------
package fp_mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_REQ = 4;

  // FP8 layout: [7] sign, [6:4] exponent, [3:0] mantissa, exponent bias 3.
  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 4;
  localparam int MAN_MSB  = 3;
  localparam int BIAS     = 3;
  localparam int FP8_W    = SIGN_BIT + 1;

endpackage

// File: rtl/fp_mul_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_mul_rr_arbiter_if
// Request/response channels between the operand loaders and the arbiter.
//   req_valid/req_ready : per-requester request handshake
//   req_a/req_b         : packed operands, slice i = [8*i+7:8*i]
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_data            : product returned to the granted requester
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fp_mul_rr_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import fp_mul_arb_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [FP8_W*NUM_REQ-1:0] req_a;
  logic [FP8_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [FP8_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fp_mul_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// fp_mul_rr_arbiter_rr_pick
// Combinational round-robin selector: first set bit of req at or above ptr,
// wrapping to bit 0.
//   req   : request vector
//   ptr   : highest-priority index this cycle (always < NUM_REQ)
//   grant : one-hot grant (all zero when no request)
//   idx   : binary index of the granted request
//   any   : at least one request present
// -----------------------------------------------------------------------------
module fp_mul_rr_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    int sum;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned; otherwise synthesis infers latches.
    any   = 1'b0;
    idx   = '0;
    grant = '0;
    sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = int'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        idx = ID_W'(sum);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = any && (idx == ID_W'(i));
    end
  end

endmodule

// File: rtl/fp_mul_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mul_rr_arbiter
// Shares one external FP8 multiplier between NUM_REQ requesters with
// round-robin arbitration. Operands are registered toward the multiplier and
// the product is registered back to the granted requester.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request/response channels (slave modport)
//   mul_a/mul_b : registered operands to the multiplier
//   mul_result  : multiplier output, sampled MUL_LAT cycles after operands
//   busy        : high while an operation is in flight (state != IDLE)
//   grant_id    : requester currently owning the multiplier
// Parameters: NUM_REQ (2..4), MUL_LAT (>=1, 1 = combinational multiplier).
// -----------------------------------------------------------------------------
module fp_mul_rr_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fp_mul_rr_arbiter_if.slave         bus,
  output logic [FP8_W-1:0]           mul_a,
  output logic [FP8_W-1:0]           mul_b,
  input  logic [FP8_W-1:0]           mul_result,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int              ID_W     = $clog2(NUM_REQ);
  localparam int              LAT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MUL_LAT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr;
  logic [LAT_W-1:0]     lat_cnt;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [FP8_W-1:0]     rsp_data_q;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic [FP8_W-1:0]     sel_a;
  logic [FP8_W-1:0]     sel_b;
  logic                 rsp_hs;

  fp_mul_rr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Operand slice of the requester chosen this cycle.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_a = bus.req_a[FP8_W*i +: FP8_W];
        sel_b = bus.req_b[FP8_W*i +: FP8_W];
      end
    end
  end

  // Next state and request acceptance. req_ready also depends on rst_n so a
  // requester holding valid during reset never sees a spurious accept.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    rsp_hs        = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n) bus.req_ready = pick_grant;
        if (pick_any) state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        rsp_hs = bus.rsp_ready[grant_id];
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      lat_cnt     <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            mul_a    <= sel_a;
            mul_b    <= sel_b;
            grant_id <= pick_idx;
            lat_cnt  <= LAT_INIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            rsp_data_q            <= mul_result;
            rsp_valid_q[grant_id] <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          // Priority moves past the requester just served, only once its
          // response has been consumed.
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            rr_ptr      <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fp_mul_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_rr_arbiter
// Two arbiter instances: a (NUM_REQ=2, MUL_LAT=1) and b (NUM_REQ=3, MUL_LAT=3).
// The multiplier stub returns mul_a + mul_b (mod 256) after MUL_LAT cycles so
// every product is easy to trace by hand.
// -----------------------------------------------------------------------------
module tb_fp_mul_rr_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;

  fp_mul_rr_arbiter_if #(.NUM_REQ(2)) bus_a ();
  fp_mul_rr_arbiter_if #(.NUM_REQ(3)) bus_b ();

  logic [7:0] mul_a_a, mul_b_a, mul_res_a;
  logic [7:0] mul_a_b, mul_b_b, mul_res_b;
  logic       busy_a, busy_b;
  logic [0:0] gid_a;
  logic [1:0] gid_b;

  fp_mul_rr_arbiter #(.NUM_REQ(2), .MUL_LAT(LAT_A)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n_a),
    .bus        (bus_a),
    .mul_a      (mul_a_a),
    .mul_b      (mul_b_a),
    .mul_result (mul_res_a),
    .busy       (busy_a),
    .grant_id   (gid_a)
  );

  fp_mul_rr_arbiter #(.NUM_REQ(3), .MUL_LAT(LAT_B)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n_b),
    .bus        (bus_b),
    .mul_a      (mul_a_b),
    .mul_b      (mul_b_b),
    .mul_result (mul_res_b),
    .busy       (busy_b),
    .grant_id   (gid_b)
  );

  // Multiplier stubs: combinational for a, two register stages for b.
  logic [7:0] pipe_b0, pipe_b1;
  assign mul_res_a = mul_a_a + mul_b_a;
  always @(posedge clk) begin
    pipe_b0 <= mul_a_b + mul_b_b;
    pipe_b1 <= pipe_b0;
  end
  assign mul_res_b = pipe_b1;

  // Uniform 4-wide views of both instances, index 0 = a, 1 = b.
  logic [3:0]      rv [2];
  logic [3:0]      rr [2];
  logic [3:0][7:0] ra [2];
  logic [3:0][7:0] rb [2];

  assign bus_a.req_valid = rv[0][1:0];
  assign bus_a.rsp_ready = rr[0][1:0];
  assign bus_a.req_a     = {ra[0][1], ra[0][0]};
  assign bus_a.req_b     = {rb[0][1], rb[0][0]};
  assign bus_b.req_valid = rv[1][2:0];
  assign bus_b.rsp_ready = rr[1][2:0];
  assign bus_b.req_a     = {ra[1][2], ra[1][1], ra[1][0]};
  assign bus_b.req_b     = {rb[1][2], rb[1][1], rb[1][0]};

  logic [3:0] rdy [2], rsp_v [2], gid [2];
  logic [7:0] rsp_d [2], ma [2], mb [2];
  logic       busy [2];

  assign rdy[0]   = {2'b00, bus_a.req_ready};
  assign rdy[1]   = {1'b0,  bus_b.req_ready};
  assign rsp_v[0] = {2'b00, bus_a.rsp_valid};
  assign rsp_v[1] = {1'b0,  bus_b.rsp_valid};
  assign gid[0]   = {3'b000, gid_a};
  assign gid[1]   = {2'b00,  gid_b};
  assign rsp_d[0] = bus_a.rsp_data;
  assign rsp_d[1] = bus_b.rsp_data;
  assign ma[0]    = mul_a_a;
  assign ma[1]    = mul_a_b;
  assign mb[0]    = mul_b_a;
  assign mb[1]    = mul_b_b;
  assign busy[0]  = busy_a;
  assign busy[1]  = busy_b;

  // Requesters must hold req_valid until req_ready.
  logic [3:0] pend_a = 4'b0;
  logic [3:0] pend_b = 4'b0;
  always @(posedge clk) begin
    if (rst_n_a) assert ((pend_a & ~rv[0]) == 4'b0)
      else $error("protocol: instance a req_valid dropped before req_ready");
    if (rst_n_b) assert ((pend_b & ~rv[1]) == 4'b0)
      else $error("protocol: instance b req_valid dropped before req_ready");
    pend_a <= rv[0] & ~rdy[0];
    pend_b <= rv[1] & ~rdy[1];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int              d;
    logic [3:0]      valid;
    logic [3:0]      rsp_rdy;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int              exp_g;
    logic [7:0]      exp_d;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input int d, input logic [3:0] v, input logic [3:0] r,
                              input logic [31:0] a, input logic [31:0] b,
                              input int g, input logic [7:0] e);
    vec_t t;
    t.d = d; t.valid = v; t.rsp_rdy = r; t.a = a; t.b = b; t.exp_g = g; t.exp_d = e;
    return t;
  endfunction

  // Drive one transaction, then follow it through WAIT into the first RESP
  // cycle. The granted requester drops valid after its handshake; the others
  // keep requesting.
  task automatic run_vec(input int idx);
    vec_t       v;
    int         n, g, lat;
    logic [3:0] oh;
    v   = vecs[idx];
    g   = v.exp_g;
    lat = (v.d == 0) ? LAT_A : LAT_B;
    oh  = 4'b0001 << g;
    @(posedge clk); #1;
    rv[v.d] = v.valid; ra[v.d] = v.a; rb[v.d] = v.b; rr[v.d] = v.rsp_rdy;
    n = 0;
    @(negedge clk);
    while (rdy[v.d] == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_req_ready", idx), 32'(rdy[v.d]), 32'(oh));
    if (rdy[v.d] == 4'b0) return;
    @(posedge clk); #1;
    rv[v.d][g] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check($sformatf("v%0d_wait%0d_rsp_valid", idx, k), 32'(rsp_v[v.d]), 32'h0);
      check($sformatf("v%0d_wait%0d_req_ready", idx, k), 32'(rdy[v.d]), 32'h0);
      check($sformatf("v%0d_wait%0d_mul_a", idx, k), 32'(ma[v.d]), 32'(v.a[g]));
      check($sformatf("v%0d_wait%0d_mul_b", idx, k), 32'(mb[v.d]), 32'(v.b[g]));
      if (k == 1) begin
        check($sformatf("v%0d_busy", idx), 32'(busy[v.d]), 32'h1);
        check($sformatf("v%0d_grant_id", idx), 32'(gid[v.d]), 32'(g));
      end
    end
    @(negedge clk);
    check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_v[v.d]), 32'(oh));
    check($sformatf("v%0d_rsp_data", idx), 32'(rsp_d[v.d]), 32'(v.exp_d));
    check($sformatf("v%0d_resp_mul_a", idx), 32'(ma[v.d]), 32'(v.a[g]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Instance a: 2 requesters, combinational multiplier.
    vecs[0]  = mk(0, 4'b0001, 4'b0011, 32'h0000_0030, 32'h0000_0041, 0, 8'h71);
    vecs[1]  = mk(0, 4'b0011, 4'b0011, 32'h0000_5612, 32'h0000_7834, 0, 8'h46);
    vecs[2]  = mk(0, 4'b0011, 4'b0011, 32'h0000_569A, 32'h0000_7801, 1, 8'hCE);
    vecs[3]  = mk(0, 4'b0011, 4'b0011, 32'h0000_F09A, 32'h0000_2001, 0, 8'h9B);
    vecs[4]  = mk(0, 4'b0011, 4'b0011, 32'h0000_F080, 32'h0000_2080, 1, 8'h10);
    vecs[5]  = mk(0, 4'b0011, 4'b0001, 32'h0000_0F80, 32'h0000_0F80, 0, 8'h00);
    vecs[6]  = mk(0, 4'b0011, 4'b0001, 32'h0000_0F11, 32'h0000_0F22, 1, 8'h1E);
    vecs[7]  = mk(0, 4'b0001, 4'b0011, 32'h0000_0011, 32'h0000_0022, 0, 8'h33);
    // Instance b: 3 requesters, MUL_LAT=3, pointer wrap 2 -> 0 -> 1.
    vecs[8]  = mk(1, 4'b0100, 4'b0111, 32'h0025_0000, 32'h0013_0000, 2, 8'h38);
    vecs[9]  = mk(1, 4'b0011, 4'b0111, 32'h0000_0A01, 32'h0000_0B02, 0, 8'h03);
    vecs[10] = mk(1, 4'b0111, 4'b0111, 32'h0040_0A77, 32'h0040_0B11, 1, 8'h15);
    vecs[11] = mk(1, 4'b0101, 4'b0111, 32'h0040_0077, 32'h0040_0011, 2, 8'h80);
    vecs[12] = mk(1, 4'b0001, 4'b0111, 32'h0000_0077, 32'h0000_0011, 0, 8'h88);

    // Reset state, with requesters already asserting valid.
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 4'b0011; rr[d] = 4'b0; ra[d] = '0; rb[d] = '0;
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_req_ready", d), 32'(rdy[d]), 32'h0);
      check($sformatf("rst%0d_rsp_valid", d), 32'(rsp_v[d]), 32'h0);
      check($sformatf("rst%0d_rsp_data", d), 32'(rsp_d[d]), 32'h0);
      check($sformatf("rst%0d_busy", d), 32'(busy[d]), 32'h0);
      check($sformatf("rst%0d_grant_id", d), 32'(gid[d]), 32'h0);
      check($sformatf("rst%0d_mul_a", d), 32'(ma[d]), 32'h0);
      rv[d] = 4'b0;
    end
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Single request on a: 0x30 + 0x41 -> 0x71.
    run_vec(0);

    // Reset in the middle of WAIT: served requester 1 (pointer advanced),
    // then everything clears and the pointer returns to 0.
    @(posedge clk); #1;
    rv[0] = 4'b0010; ra[0][1] = 8'h5A; rb[0][1] = 8'h01;
    n = 0;
    @(negedge clk);
    while (!busy[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_busy", 32'(busy[0]), 32'h1);
    check("midrst_grant_id", 32'(gid[0]), 32'h1);
    #1;
    rst_n_a = 1'b0;
    rv[0]   = 4'b0;
    #1;
    check("midrst_req_ready", 32'(rdy[0]), 32'h0);
    check("midrst_rsp_valid", 32'(rsp_v[0]), 32'h0);
    check("midrst_rsp_data", 32'(rsp_d[0]), 32'h0);
    check("midrst_busy_low", 32'(busy[0]), 32'h0);
    check("midrst_grant_id_low", 32'(gid[0]), 32'h0);
    check("midrst_mul_a", 32'(ma[0]), 32'h0);
    check("midrst_mul_b", 32'(mb[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;

    // Contention: alternating grants 0,1,0,1,0,1.
    for (int i = 1; i <= 6; i++) run_vec(i);

    // Backpressure on requester 1 while requester 0 waits; rsp_ready[0]
    // being high must not release requester 1's response.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_rsp_valid", k), 32'(rsp_v[0]), 32'h2);
      check($sformatf("bp%0d_rsp_data", k), 32'(rsp_d[0]), 32'h1E);
      check($sformatf("bp%0d_req_ready", k), 32'(rdy[0]), 32'h0);
      check($sformatf("bp%0d_busy", k), 32'(busy[0]), 32'h1);
    end
    @(posedge clk); #1;
    rr[0] = 4'b0011;
    @(negedge clk);
    check("bp_release_rsp_valid", 32'(rsp_v[0]), 32'h2);
    run_vec(7);

    // rsp_ready was already high: completion in the first RESP cycle.
    @(negedge clk);
    check("early_ready_busy", 32'(busy[0]), 32'h0);
    check("early_ready_rsp_valid", 32'(rsp_v[0]), 32'h0);

    // Instance b: wrap-around and multi-cycle latency.
    for (int i = 8; i <= 12; i++) run_vec(i);
    @(negedge clk);
    check("b_final_busy", 32'(busy[1]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
